// File: rtl/adaptive_filter_pkg.sv
// Shared types, default constants and saturation helper for the serial LMS filter.
package adaptive_filter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILT,
        ERR,
        UPD,
        OUT
    } state_t;

    typedef enum logic {
        MODE_LMS  = 1'b0,
        MODE_SIGN = 1'b1
    } mode_t;

    // Default configuration and the constants derived from it.
    localparam int DEF_WIDTH = 32;
    localparam int DEF_FRAC  = 20;
    localparam int DEF_TAPS  = 4;
    localparam logic [DEF_WIDTH-1:0] ONE = 32'(1) <<< DEF_FRAC;
    localparam int ACC_W = 2 * DEF_WIDTH + $clog2(DEF_TAPS);

    // Widest intermediate the saturation helper accepts.
    localparam int SAT_W = 128;

    typedef struct packed {
        logic signed [SAT_W-1:0] value;
        logic                    ovr;
    } sat_t;

    // Clamp a wide signed value into a signed 'width'-bit range; ovr flags a clamp.
    function automatic sat_t sat_trunc(input logic signed [SAT_W-1:0] value, input int width);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_t                    r;
        hi      = (128'sd1 <<< (width - 1)) - 128'sd1;
        lo      = -hi - 128'sd1;
        r.value = value;
        r.ovr   = 1'b0;
        if (value > hi) begin
            r.value = hi;
            r.ovr   = 1'b1;
        end else if (value < lo) begin
            r.value = lo;
            r.ovr   = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/adaptive_filter_serial_fx_mul_sat.sv
// Combinational signed multiplier: full product plus Q-format (>>> FRAC) saturated result.
module fx_mul_sat
    import adaptive_filter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 20
) (
    input  logic signed [WIDTH:0]     i_a,
    input  logic signed [WIDTH-1:0]   i_b,
    output logic signed [2*WIDTH:0]   o_prod,
    output logic signed [WIDTH-1:0]   o_y,
    output logic                      o_ovr
);

    sat_t w_sat;

    // Full-precision product, then rescale and clamp back to WIDTH bits.
    always_comb begin
        o_prod = (2*WIDTH+1)'(i_a) * (2*WIDTH+1)'(i_b);
        w_sat  = sat_trunc(128'(o_prod >>> FRAC), WIDTH);
        o_y    = WIDTH'(w_sat.value);
        o_ovr  = w_sat.ovr;
    end

endmodule

// File: rtl/adaptive_filter_serial.sv
// Time-multiplexed LMS adaptive FIR: one shared multiplier walks filter, error and update phases.
module adaptive_filter_serial
    import adaptive_filter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 20,
    parameter int TAPS  = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [WIDTH-1:0] i_din,
    input  logic signed [WIDTH-1:0] i_desired,
    input  logic [WIDTH-1:0]        i_step_size,
    input  logic                    i_mode,
    input  logic                    i_freeze,
    input  logic                    i_ovr,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [WIDTH-1:0] o_dout,
    output logic signed [WIDTH-1:0] o_error,
    output logic                    o_ovr,
    output logic [TAPS*WIDTH-1:0]   o_weights
);

    localparam int CNT_W    = $clog2(TAPS);
    localparam int ACC_BITS = 2 * WIDTH + $clog2(TAPS);
    localparam logic [CNT_W-1:0]        LAST_TAP = CNT_W'(TAPS - 1);
    localparam logic signed [WIDTH-1:0] Q_ONE    = {{(WIDTH-1){1'b0}}, 1'b1} <<< FRAC;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [CNT_W-1:0]           r_cnt;
    logic signed [WIDTH-1:0]    r_x     [TAPS];
    logic signed [WIDTH-1:0]    r_w     [TAPS];
    logic signed [WIDTH-1:0]    r_w_buf [TAPS];
    logic signed [ACC_BITS-1:0] r_acc;
    logic signed [WIDTH-1:0]    r_desired;
    logic [WIDTH-1:0]           r_mu;
    mode_t                      r_mode;
    logic                       r_freeze;
    logic                       r_ovr;
    logic signed [WIDTH-1:0]    r_mu_e;
    logic signed [WIDTH-1:0]    r_dout;
    logic signed [WIDTH-1:0]    r_error;

    sat_t                       w_dout_sat;
    sat_t                       w_e_sat;
    sat_t                       w_wsum_sat;
    logic signed [WIDTH-1:0]    w_dout;
    logic signed [WIDTH-1:0]    w_e;
    logic signed [WIDTH-1:0]    w_e_term;
    logic signed [WIDTH-1:0]    w_w_new;
    logic signed [WIDTH:0]      w_mul_a;
    logic signed [WIDTH-1:0]    w_mul_b;
    logic signed [2*WIDTH:0]    w_mul_prod;
    logic signed [WIDTH-1:0]    w_mul_y;
    logic                       w_mul_ovr;

    fx_mul_sat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_mul (
        .i_a    (w_mul_a),
        .i_b    (w_mul_b),
        .o_prod (w_mul_prod),
        .o_y    (w_mul_y),
        .o_ovr  (w_mul_ovr)
    );

    // State register.
    // NOTE: clocked blocks use <= so every register samples pre-edge values; = here would create ordering races.
    always_ff @(posedge clk) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs.
    // NOTE: every output gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        case (r_state)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) w_state_nxt = FILT;
            end
            FILT:    if (r_cnt == LAST_TAP) w_state_nxt = ERR;
            ERR:     w_state_nxt = r_freeze ? OUT : UPD;
            UPD:     if (r_cnt == LAST_TAP) w_state_nxt = OUT;
            OUT: begin
                m_valid = 1'b1;
                if (m_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Error path: rescale the accumulator, form the error and the adaptation term.
    always_comb begin
        w_dout_sat = sat_trunc(128'(r_acc >>> FRAC), WIDTH);
        w_dout     = WIDTH'(w_dout_sat.value);
        w_e_sat    = sat_trunc(128'(r_desired) - 128'(w_dout), WIDTH);
        w_e        = WIDTH'(w_e_sat.value);
        w_e_term   = w_e;
        if (r_mode == MODE_SIGN) begin
            if (w_e == '0)        w_e_term = '0;
            else if (w_e[WIDTH-1]) w_e_term = -Q_ONE;
            else                  w_e_term = Q_ONE;
        end
    end

    // Operand mux for the shared multiplier; mu is zero-extended, signed operands sign-extended.
    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        case (r_state)
            FILT: begin
                w_mul_a = {r_w[r_cnt][WIDTH-1], r_w[r_cnt]};
                w_mul_b = r_x[r_cnt];
            end
            ERR: begin
                w_mul_a = {1'b0, r_mu};
                w_mul_b = w_e_term;
            end
            UPD: begin
                w_mul_a = {r_mu_e[WIDTH-1], r_mu_e};
                w_mul_b = r_x[r_cnt];
            end
            default: ;
        endcase
    end

    // Candidate weight for the tap being updated, from the pre-update weight.
    always_comb begin
        w_wsum_sat = sat_trunc(128'(r_w[r_cnt]) + 128'(w_mul_y), WIDTH);
        w_w_new    = WIDTH'(w_wsum_sat.value);
    end

    // Staging buffer for updated weights; holds nothing meaningful outside UPD.
    // NOTE: the buffer is not reset because it is always rewritten before it is read, and reset only clears architectural state.
    always_ff @(posedge clk) begin
        if (r_state == UPD) r_w_buf[r_cnt] <= w_w_new;
    end

    // Datapath: sample capture, accumulation, error registers, and atomic weight commit.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int j = 0; j < TAPS; j++) begin
                r_x[j] <= '0;
                r_w[j] <= '0;
            end
            r_cnt     <= '0;
            r_acc     <= '0;
            r_desired <= '0;
            r_mu      <= '0;
            r_mode    <= MODE_LMS;
            r_freeze  <= 1'b0;
            r_ovr     <= 1'b0;
            r_mu_e    <= '0;
            r_dout    <= '0;
            r_error   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (s_valid) begin
                        r_x[0] <= i_din;
                        for (int j = 1; j < TAPS; j++) r_x[j] <= r_x[j-1];
                        r_desired <= i_desired;
                        r_mu      <= i_step_size;
                        r_mode    <= mode_t'(i_mode);
                        r_freeze  <= i_freeze;
                        r_ovr     <= i_ovr;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                    end
                end
                FILT: begin
                    r_acc <= r_acc + ACC_BITS'(w_mul_prod);
                    r_cnt <= (r_cnt == LAST_TAP) ? '0 : r_cnt + CNT_W'(1);
                end
                ERR: begin
                    r_dout  <= w_dout;
                    r_error <= w_e;
                    r_mu_e  <= w_mul_y;
                    r_ovr   <= r_ovr | w_dout_sat.ovr | w_e_sat.ovr | w_mul_ovr;
                    r_cnt   <= '0;
                end
                UPD: begin
                    r_ovr <= r_ovr | w_mul_ovr | w_wsum_sat.ovr;
                    if (r_cnt == LAST_TAP) begin
                        for (int j = 0; j < TAPS; j++)
                            r_w[j] <= (j == TAPS - 1) ? w_w_new : r_w_buf[j];
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output view of the committed weights and result registers.
    always_comb begin
        o_weights = '0;
        for (int j = 0; j < TAPS; j++) o_weights[j*WIDTH +: WIDTH] = r_w[j];
        o_dout  = r_dout;
        o_error = r_error;
        o_ovr   = r_ovr;
    end

endmodule

// File: tb/tb_adaptive_filter_serial.sv
// Self-checking bench for adaptive_filter_serial: reference model feeds a scoreboard queue.
module tb_adaptive_filter_serial;

    localparam int W = 32;
    localparam int F = 20;
    localparam int T = 4;
    localparam logic signed [W-1:0] Q1 = 32'sh0010_0000;

    logic           clk;
    logic           rstn;
    logic           s_valid;
    logic           s_ready;
    logic [W-1:0]   i_din;
    logic [W-1:0]   i_desired;
    logic [W-1:0]   i_step_size;
    logic           i_mode;
    logic           i_freeze;
    logic           i_ovr;
    logic           m_valid;
    logic           m_ready;
    logic [W-1:0]   o_dout;
    logic [W-1:0]   o_error;
    logic           o_ovr;
    logic [T*W-1:0] o_weights;

    adaptive_filter_serial #(.WIDTH(W), .FRAC(F), .TAPS(T)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .i_din       (i_din),
        .i_desired   (i_desired),
        .i_step_size (i_step_size),
        .i_mode      (i_mode),
        .i_freeze    (i_freeze),
        .i_ovr       (i_ovr),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .o_dout      (o_dout),
        .o_error     (o_error),
        .o_ovr       (o_ovr),
        .o_weights   (o_weights)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   dout;
        logic [W-1:0]   err;
        logic           ovr;
        logic [T*W-1:0] weights;
    } exp_t;

    exp_t                  sb[$];
    exp_t                  cur;
    logic signed [W-1:0]   m_x [T];
    logic signed [W-1:0]   m_w [T];
    int                    checks = 0;
    int                    errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic signed [W-1:0] sat(input logic signed [127:0] v, inout logic ovr);
        if (v > 128'sh7FFF_FFFF) begin
            ovr = 1'b1;
            return 32'sh7FFF_FFFF;
        end
        if (v < -128'sh8000_0000) begin
            ovr = 1'b1;
            return 32'sh8000_0000;
        end
        return v[W-1:0];
    endfunction

    task automatic model_clear();
        for (int k = 0; k < T; k++) begin
            m_x[k] = '0;
            m_w[k] = '0;
        end
        sb.delete();
    endtask

    // Reference transaction: whole-sample arithmetic in 128-bit signed integers.
    task automatic model_push(input logic signed [W-1:0] din, input logic signed [W-1:0] desired,
                              input logic [W-1:0] mu, input logic mode, input logic freeze,
                              input logic ovr_in);
        logic signed [127:0] acc;
        logic signed [127:0] prod;
        logic signed [W-1:0] dout;
        logic signed [W-1:0] e;
        logic signed [W-1:0] eterm;
        logic signed [W-1:0] mue;
        logic signed [W-1:0] delta;
        logic                ov;
        exp_t                ex;
        for (int k = T - 1; k > 0; k--) m_x[k] = m_x[k-1];
        m_x[0] = din;
        acc = '0;
        for (int k = 0; k < T; k++) acc = acc + 128'(m_x[k]) * 128'(m_w[k]);
        ov   = ovr_in;
        dout = sat(acc >>> F, ov);
        e    = sat(128'(desired) - 128'(dout), ov);
        if (mode) eterm = (e > 0) ? Q1 : ((e < 0) ? -Q1 : 32'sd0);
        else      eterm = e;
        prod = $signed({96'd0, mu}) * 128'(eterm);
        mue  = sat(prod >>> F, ov);
        if (!freeze) begin
            for (int k = 0; k < T; k++) begin
                delta  = sat((128'(mue) * 128'(m_x[k])) >>> F, ov);
                m_w[k] = sat(128'(m_w[k]) + 128'(delta), ov);
            end
        end
        ex.dout = dout;
        ex.err  = e;
        ex.ovr  = ov;
        for (int k = 0; k < T; k++) ex.weights[k*W +: W] = m_w[k];
        sb.push_back(ex);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn    = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        model_clear();
    endtask

    // Present a sample, wait (bounded) for acceptance, and record the expectation at the accept edge.
    task automatic send(input logic signed [W-1:0] din, input logic signed [W-1:0] desired,
                        input logic [W-1:0] mu, input logic mode, input logic freeze, input logic ovr_in);
        int n;
        @(negedge clk);
        s_valid     = 1'b1;
        i_din       = din;
        i_desired   = desired;
        i_step_size = mu;
        i_mode      = mode;
        i_freeze    = freeze;
        i_ovr       = ovr_in;
        n = 0;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) check("accept_timeout", 128'(s_ready), 128'(1));
        @(posedge clk);
        model_push(din, desired, mu, mode, freeze, ovr_in);
        #1 s_valid = 1'b0;
    endtask

    // Count cycles from the accept edge until m_valid, then compare against the scoreboard head.
    task automatic wait_out(input int exp_lat, input string tag);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!m_valid && lat < 100);
        check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        check({tag, "_sb_level"}, 128'(sb.size() > 0), 128'(1));
        if (sb.size() > 0) cur = sb.pop_front();
        check({tag, "_dout"},    128'(o_dout),    128'(cur.dout));
        check({tag, "_error"},   128'(o_error),   128'(cur.err));
        check({tag, "_ovr"},     128'(o_ovr),     128'(cur.ovr));
        check({tag, "_weights"}, 128'(o_weights), 128'(cur.weights));
    endtask

    task automatic release_out();
        m_ready = 1'b1;
        @(posedge clk);
        #1 m_ready = 1'b0;
    endtask

    initial begin : main
        logic signed [W-1:0] rd;
        logic signed [W-1:0] rq;
        logic [W-1:0]        rmu;
        logic                rmode;
        logic                rfrz;
        rstn = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        i_din = '0; i_desired = '0; i_step_size = '0;
        i_mode = 1'b0; i_freeze = 1'b0; i_ovr = 1'b0;

        // Reset state
        do_reset();
        check("rst_s_ready", 128'(s_ready), 128'(1));
        check("rst_m_valid", 128'(m_valid), 128'(0));
        check("rst_weights", 128'(o_weights), 128'(0));
        check("rst_dout",    128'(o_dout), 128'(0));
        check("rst_error",   128'(o_error), 128'(0));
        check("rst_ovr",     128'(o_ovr), 128'(0));

        // Single LMS update
        send(Q1, 32'sh0008_0000, 32'h0008_0000, 1'b0, 1'b0, 1'b0);
        wait_out(10, "s1");
        check("s1_dout_c",  128'(o_dout), 128'(0));
        check("s1_error_c", 128'(o_error), 128'(32'h0008_0000));
        check("s1_w_c",     128'(o_weights), {96'd0, 32'h0004_0000});
        release_out();

        // Freeze
        do_reset();
        send(Q1, 32'sh0008_0000, 32'h0008_0000, 1'b0, 1'b1, 1'b0);
        wait_out(6, "frz");
        check("frz_error_c", 128'(o_error), 128'(32'h0008_0000));
        check("frz_w_c",     128'(o_weights), 128'(0));
        release_out();

        // Sign-error mode with negative error
        do_reset();
        send(Q1, -32'sd104858, 32'h0008_0000, 1'b1, 1'b0, 1'b0);
        wait_out(10, "sgn");
        check("sgn_error_c", 128'(o_error), 128'(32'hFFFE_6666));
        check("sgn_w0_c",    128'(o_weights[W-1:0]), 128'(32'hFFF8_0000));
        check("sgn_ovr_c",   128'(o_ovr), 128'(0));
        release_out();

        // Saturation: preload w0 = 1.0, then force error clamp, then a clean sample with mu = 0
        do_reset();
        send(Q1, Q1, 32'h0010_0000, 1'b0, 1'b0, 1'b0);
        wait_out(10, "pre");
        check("pre_w0_c", 128'(o_weights[W-1:0]), 128'(32'h0010_0000));
        release_out();
        send(-Q1, 32'sh7FFF_FFFF, 32'h0008_0000, 1'b0, 1'b0, 1'b0);
        wait_out(10, "sat");
        check("sat_error_c", 128'(o_error), 128'(32'h7FFF_FFFF));
        check("sat_ovr_c",   128'(o_ovr), 128'(1));
        release_out();
        send(32'sd0, 32'sd0, 32'h0, 1'b0, 1'b0, 1'b0);
        wait_out(10, "clean");
        check("clean_ovr_c", 128'(o_ovr), 128'(0));
        release_out();

        // Mixed samples against the model
        do_reset();
        for (int i = 0; i < 5; i++) begin
            rd    = int'($urandom_range(0, 32'h0020_0000)) - 32'sh0010_0000;
            rq    = int'($urandom_range(0, 32'h0020_0000)) - 32'sh0010_0000;
            rmu   = $urandom_range(0, 32'h0004_0000);
            rmode = 1'($urandom_range(0, 1));
            rfrz  = (i == 3);
            send(rd, rq, rmu, rmode, rfrz, i == 2);
            wait_out(rfrz ? 6 : 10, "mix");
            release_out();
        end

        // Backpressure: result held 20 cycles while a new sample waits
        send(Q1, 32'sh0008_0000, 32'h0008_0000, 1'b0, 1'b0, 1'b0);
        wait_out(10, "bp1");
        s_valid     = 1'b1;
        i_din       = 32'hFFF0_0000;
        i_desired   = 32'h0002_0000;
        i_step_size = 32'h0002_0000;
        i_mode      = 1'b0;
        i_freeze    = 1'b0;
        i_ovr       = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_m_valid", 128'(m_valid), 128'(1));
            check("bp_s_ready", 128'(s_ready), 128'(0));
            check("bp_dout",    128'(o_dout), 128'(cur.dout));
            check("bp_error",   128'(o_error), 128'(cur.err));
            check("bp_weights", 128'(o_weights), 128'(cur.weights));
        end
        release_out();
        check("bp_idle_s_ready", 128'(s_ready), 128'(1));
        check("bp_idle_m_valid", 128'(m_valid), 128'(0));
        @(posedge clk);
        model_push(-Q1, 32'sh0002_0000, 32'h0002_0000, 1'b0, 1'b0, 1'b0);
        #1;
        check("bp_accepted", 128'(s_ready), 128'(0));
        s_valid = 1'b0;
        wait_out(10, "bp2");
        release_out();

        // Reset in the middle of the weight update
        send(Q1, 32'sh0008_0000, 32'h0008_0000, 1'b0, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("mid_weights", 128'(o_weights), 128'(0));
        check("mid_m_valid", 128'(m_valid), 128'(0));
        check("mid_s_ready", 128'(s_ready), 128'(1));
        check("mid_ovr",     128'(o_ovr), 128'(0));
        @(negedge clk);
        rstn = 1'b1;
        model_clear();
        send(Q1, 32'sh0008_0000, 32'h0008_0000, 1'b0, 1'b0, 1'b0);
        wait_out(10, "post");
        check("post_error_c", 128'(o_error), 128'(32'h0008_0000));
        check("post_w_c",     128'(o_weights), {96'd0, 32'h0004_0000});
        release_out();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adaptive_filter_serial.md
Name: adaptive_filter_serial

Overview:
- Time-multiplexed LMS adaptive FIR with a single shared multiply-saturate datapath.
- Processes one sample per transaction over valid/ready streams: filter, error, then weight update.
- Adds adaptation modes (LMS, sign-error LMS), an adaptation freeze, and saturating Q-format arithmetic with overflow reporting.
- Scales to large TAPS at one multiplier of area. Successor to the fully-parallel combinational-update filter.

Parameters:
- WIDTH, 32, sample, coefficient and step-size width; two's-complement.
- FRAC, 20, fractional bits; 1.0 = 2^FRAC.
- TAPS, 4, filter length; must be >= 2.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- s_valid  in  1  input sample valid
- s_ready  out  1  block accepts a sample
- i_din  in  WIDTH  signed input sample
- i_desired  in  WIDTH  signed desired sample, captured with i_din
- i_step_size  in  WIDTH  unsigned mu, captured at accept
- i_mode  in  1  0 = LMS, 1 = sign-error LMS; captured at accept
- i_freeze  in  1  1 = skip weight update; captured at accept
- i_ovr  in  1  upstream overflow flag, captured at accept
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts result
- o_dout  out  WIDTH  filter output
- o_error  out  WIDTH  desired minus dout
- o_ovr  out  1  overflow for this result
- o_weights  out  TAPS*WIDTH  current weights; tap k in bits [k*WIDTH +: WIDTH]

Behaviour:
- Reset (rstn = 0 at a clk edge):
  - FSM to IDLE; delay line, weights, o_dout, o_error, o_ovr, m_valid all cleared to 0.
  - s_ready = 1 in the cycle after reset deasserts.
  - Reset in any state aborts the transaction; a partial weight update is discarded with no partial write-back.
- FSM states:
  - IDLE: s_ready = 1. On s_valid & s_ready:
    - shift i_din into x[0] (x[k] moves to x[k+1], x[TAPS-1] drops);
    - capture desired, mu, mode, freeze, ovr;
    - clear the accumulator; go to FILT.
  - FILT: k = 0..TAPS-1, one tap per cycle; acc += w[k]*x[k] at full 2*WIDTH product precision. After k = TAPS-1, go to ERR.
  - ERR (1 cycle):
    - dout = sat(acc >>> FRAC);
    - e = sat(desired - dout);
    - e_term = e (LMS), or +1.0 / -1.0 / 0 by sign of e (sign mode);
    - mu_e = sat((mu*e_term) >>> FRAC).
    - Next state: OUT if freeze, else UPD.
  - UPD: k = 0..TAPS-1, one tap per cycle. w_new[k] = sat(w[k] + sat((mu_e*x[k]) >>> FRAC)), computed from pre-update weights. After the last tap, go to OUT.
  - OUT: m_valid = 1; o_dout, o_error and o_ovr are stable. On m_ready, go to IDLE.
- Weight write-back:
  - Weights are buffered and all TAPS weights commit together on the UPD-to-OUT transition.
  - o_weights never shows a partially updated vector.
- Latency, counted from the accept edge:
  - freeze = 0: m_valid rises 2*TAPS+2 cycles later;
  - freeze = 1: m_valid rises TAPS+2 cycles later.
  - Throughput is 1 sample per latency + 1 cycles when m_ready = 1.
- Handshake rules:
  - s_ready = 0 outside IDLE.
  - s_valid while not ready has no effect; upstream holds data.
  - m_valid stays high with outputs unchanged until m_ready. m_ready while m_valid = 0 is ignored.
- Arithmetic:
  - >>> is arithmetic shift (truncation toward -inf).
  - sat clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - The accumulator is 2*WIDTH + clog2(TAPS) bits and never wraps.
  - mu is zero-extended before multiplying.
- Overflow:
  - o_ovr = captured i_ovr OR any sat clamp that fired in this transaction (dout, e, mu_e, delta, weight).
  - Cleared on the next accept.
- mu = 0 or e = 0: weights unchanged, and the UPD state still runs its full duration.

Decomposition:
- Package adaptive_filter_pkg holds:
  - state enum {IDLE, FILT, ERR, UPD, OUT};
  - mode enum {MODE_LMS, MODE_SIGN};
  - localparams ONE = 1 <<< FRAC and ACC_W;
  - function sat_trunc(value, width) returning the clamped value and an overflow bit.
- One sub-module, fx_mul_sat: registered-free combinational WIDTH x WIDTH signed multiply, >>> FRAC, saturate, ovr flag. It is shared by the FILT, ERR (mu*e) and UPD phases through a mux.

Test Plan:
- Single update: after reset, din = 1.0 (0x0010_0000), desired = 0.5, mu = 0.5, mode = LMS, freeze = 0 -> dout = 0, error = 0x0008_0000, w0 = 0x0004_0000, w1..w3 = 0, m_valid exactly 10 cycles after accept.
- Freeze: same stimulus with freeze = 1 -> identical dout/error, weights remain 0, m_valid 6 cycles after accept.
- Sign mode: desired = -0.1, din = 1.0, mu = 0.5, zero weights -> e < 0, w0 = -0.5 (0xFFF8_0000), o_ovr = 0.
- Saturation: preload w0 = 1.0 via a prior LMS step, then din = -1.0, desired = 0x7FFF_FFFF -> o_error = 0x7FFF_FFFF, o_ovr = 1; the next clean sample gives o_ovr = 0.
- Backpressure: hold m_ready = 0 for 20 cycles after m_valid -> outputs stable, s_ready = 0, and a held s_valid sample is not accepted until the cycle after m_ready.
- Mid-operation reset: assert rstn = 0 during UPD -> next cycle weights, delay line, m_valid = 0, s_ready = 1; a following sample behaves exactly as in scenario 1.
